lcd_stream_driver: RTL and testbench

// Parametrised LCD pixel driver. Generates HSYNC/VSYNC/DE from one clock domain and unpacks
// PIX_PER_WORD pixels per word read from a show-ahead frame FIFO fed by the SDRAM controller.

---
 rtl/lcd_timing_pkg.sv | 22 ++
 rtl/lcd_timing_gen.sv | 109 ++++++++++
 rtl/lcd_stream_driver.sv | 151 +++++++++++++++
 tb/tb_lcd_stream_driver.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// ============================================================================
// Module  : lcd_timing_pkg
// Brief   : Shared timing helpers and run-control state encodings for the LCD driver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package lcd_timing_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_stop = 2'd2;

    // Total length of a line (clocks) or frame (lines) from its four periods.
    function automatic int line_total(input int sync_len, input int back_len,
                                      input int active_len, input int front_len);
        return sync_len + back_len + active_len + front_len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_timing_gen.sv
// ============================================================================
// Module  : lcd_timing_gen
// Brief   : Raster counters, start/stop FSM and stage0 sync/DE/frame-start decode.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_SYNC   = 45,
    parameter int H_BACK   = 45,
    parameter int H_ACTIVE = 480,
    parameter int H_FRONT  = 0,
    parameter int V_SYNC   = 16,
    parameter int V_BACK   = 16,
    parameter int V_ACTIVE = 272,
    parameter int V_FRONT  = 0,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic running,
    output logic hsync,
    output logic vsync,
    output logic de,
    output logic frame_start,
    output logic line_start
);

    localparam int c_h_total = line_total(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
    localparam int c_v_total = line_total(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

    localparam logic [CNT_W-1:0] c_h_last     = CNT_W'(c_h_total - 1);
    localparam logic [CNT_W-1:0] c_v_last     = CNT_W'(c_v_total - 1);
    localparam logic [CNT_W-1:0] c_h_sync_end = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] c_v_sync_end = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] c_h_act_lo   = CNT_W'(H_SYNC + H_BACK);
    localparam logic [CNT_W-1:0] c_h_act_hi   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_act_lo   = CNT_W'(V_SYNC + V_BACK);
    localparam logic [CNT_W-1:0] c_v_act_hi   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             w_h_wrap;
    logic             w_frame_end;

    assign w_h_wrap    = (r_hcnt == c_h_last);
    assign w_frame_end = w_h_wrap && (r_vcnt == c_v_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // STOP keeps scanning so the panel always sees whole frames.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (enable) w_state_nxt = c_st_run;
            c_st_run:  if (!enable) w_state_nxt = c_st_stop;
            c_st_stop: begin
                if (enable) begin
                    w_state_nxt = c_st_run;
                end else if (w_frame_end) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (r_state == c_st_idle) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_wrap) begin
            r_hcnt <= '0;
            r_vcnt <= w_frame_end ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    always_comb begin
        running     = (r_state != c_st_idle);
        hsync       = (running && (r_hcnt < c_h_sync_end)) ? HS_POL : ~HS_POL;
        vsync       = (running && (r_vcnt < c_v_sync_end)) ? VS_POL : ~VS_POL;
        de          = running
                      && (r_hcnt >= c_h_act_lo) && (r_hcnt < c_h_act_hi)
                      && (r_vcnt >= c_v_act_lo) && (r_vcnt < c_v_act_hi);
        frame_start = running && (r_hcnt == '0) && (r_vcnt == '0);
        line_start  = (r_hcnt == '0);
    end

endmodule

`default_nettype wire

// File: rtl/lcd_stream_driver.sv
// ============================================================================
// Module  : lcd_stream_driver
// Brief   : LCD panel driver unpacking show-ahead FIFO words into registered RGB/sync.
// Revision: 1.0
// ============================================================================
`default_nettype none

module lcd_stream_driver
    import lcd_timing_pkg::*;
#(
    parameter int PIX_W        = 8,
    parameter int PIX_PER_WORD = 4,
    parameter int H_SYNC       = 45,
    parameter int H_BACK       = 45,
    parameter int H_ACTIVE     = 480,
    parameter int H_FRONT      = 0,
    parameter int V_SYNC       = 16,
    parameter int V_BACK       = 16,
    parameter int V_ACTIVE     = 272,
    parameter int V_FRONT      = 0,
    parameter bit HS_POL       = 1'b0,
    parameter bit VS_POL       = 1'b0,
    parameter int CNT_W        = 12
) (
    input  logic                            clk_lcd,
    input  logic                            lcd_rst_n,
    input  logic                            enable,
    input  logic [PIX_PER_WORD*3*PIX_W-1:0] word_data,
    input  logic                            word_empty,
    output logic                            word_rden,
    output logic                            frame_start,
    output logic                            underflow,
    input  logic                            clr_underflow,
    output logic                            lcd_dclk,
    output logic                            lcd_hsync,
    output logic                            lcd_vsync,
    output logic                            lcd_de,
    output logic [PIX_W-1:0]                lcd_r,
    output logic [PIX_W-1:0]                lcd_g,
    output logic [PIX_W-1:0]                lcd_b
);

    localparam int c_px_w   = 3 * PIX_W;
    localparam int c_word_w = PIX_PER_WORD * c_px_w;
    localparam int c_slot_w = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(PIX_PER_WORD - 1);

    logic                w_running;
    logic                w_hsync0;
    logic                w_vsync0;
    logic                w_de0;
    logic                w_fs0;
    logic                w_line_start;
    logic                w_need_word;
    logic                w_uf_set;
    logic [c_word_w-1:0] w_cur_word;

    logic [c_slot_w-1:0] r_slot;
    logic [c_word_w-1:0] r_shift;
    logic [c_px_w-1:0]   r_pix;
    logic                r_hsync;
    logic                r_vsync;
    logic                r_de;
    logic                r_fs;
    logic                r_underflow;

    lcd_timing_gen #(
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .HS_POL   (HS_POL),
        .VS_POL   (VS_POL),
        .CNT_W    (CNT_W)
    ) u_timing (
        .clk         (clk_lcd),
        .rst_n       (lcd_rst_n),
        .enable      (enable),
        .running     (w_running),
        .hsync       (w_hsync0),
        .vsync       (w_vsync0),
        .de          (w_de0),
        .frame_start (w_fs0),
        .line_start  (w_line_start)
    );

    // Slot 0 consumes the FIFO head directly; a missing word is replaced by black.
    assign w_need_word = w_de0 && (r_slot == '0);
    assign word_rden   = w_need_word && !word_empty;
    assign w_uf_set    = w_need_word && word_empty;
    assign w_cur_word  = (r_slot == '0) ? (word_empty ? '0 : word_data) : r_shift;

    always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            r_slot  <= '0;
            r_shift <= '0;
        end else begin
            if (w_line_start || !w_running) begin
                r_slot <= '0;
            end else if (w_de0) begin
                r_slot <= (r_slot == c_slot_last) ? '0 : r_slot + 1'b1;
            end
            if (w_de0) begin
                r_shift <= w_cur_word << c_px_w;
            end
        end
    end

    always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            r_underflow <= 1'b0;
        end else if (w_uf_set) begin
            r_underflow <= 1'b1;
        end else if (clr_underflow) begin
            r_underflow <= 1'b0;
        end
    end

    always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
        if (!lcd_rst_n) begin
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
            r_de    <= 1'b0;
            r_fs    <= 1'b0;
            r_pix   <= '0;
        end else begin
            r_hsync <= w_hsync0;
            r_vsync <= w_vsync0;
            r_de    <= w_de0;
            r_fs    <= w_fs0;
            r_pix   <= w_de0 ? w_cur_word[c_word_w-1 -: c_px_w] : '0;
        end
    end

    assign lcd_dclk    = clk_lcd;
    assign lcd_hsync   = r_hsync;
    assign lcd_vsync   = r_vsync;
    assign lcd_de      = r_de;
    assign frame_start = r_fs;
    assign underflow   = r_underflow;
    assign lcd_b       = r_pix[c_px_w-1 -: PIX_W];
    assign lcd_g       = r_pix[2*PIX_W-1 -: PIX_W];
    assign lcd_r       = r_pix[PIX_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_lcd_stream_driver.sv
// ============================================================================
// Module  : tb_lcd_stream_driver
// Brief   : Self-checking bench for lcd_stream_driver on a small 14x6 raster.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_lcd_stream_driver;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        enable6;
    logic        clr;
    logic [95:0] word_data;
    logic        word_empty;
    logic [95:0] word_data6;
    logic        word_empty6;

    logic       word_rden, frame_start, underflow, lcd_dclk, lcd_hsync, lcd_vsync, lcd_de;
    logic [7:0] lcd_r, lcd_g, lcd_b;
    logic       word_rden6, frame_start6, underflow6, lcd_dclk6, lcd_hsync6, lcd_vsync6, lcd_de6;
    logic [7:0] lcd_r6, lcd_g6, lcd_b6;

    int          vectors;
    int          miscompares;
    int          sidx;
    int          idx6;
    int          fifo_q[$];
    logic [23:0] exp_q[$];
    logic [23:0] exp6_q[$];
    int n_hs, n_vs, n_de, n_fs, n_rden, first_de, last_de;
    int n_hs6, n_vs6, n_de6, n_fs6, n_rden6;

    lcd_stream_driver #(
        .PIX_W(8), .PIX_PER_WORD(4),
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(8), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
    ) u_dut (
        .clk_lcd(clk), .lcd_rst_n(rst_n), .enable(enable),
        .word_data(word_data), .word_empty(word_empty), .word_rden(word_rden),
        .frame_start(frame_start), .underflow(underflow), .clr_underflow(clr),
        .lcd_dclk(lcd_dclk), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
        .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
    );

    lcd_stream_driver #(
        .PIX_W(8), .PIX_PER_WORD(4),
        .H_SYNC(2), .H_BACK(2), .H_ACTIVE(6), .H_FRONT(2),
        .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(12)
    ) u_dut6 (
        .clk_lcd(clk), .lcd_rst_n(rst_n), .enable(enable6),
        .word_data(word_data6), .word_empty(word_empty6), .word_rden(word_rden6),
        .frame_start(frame_start6), .underflow(underflow6), .clr_underflow(clr),
        .lcd_dclk(lcd_dclk6), .lcd_hsync(lcd_hsync6), .lcd_vsync(lcd_vsync6), .lcd_de(lcd_de6),
        .lcd_r(lcd_r6), .lcd_g(lcd_g6), .lcd_b(lcd_b6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word i carries bytes i*12+1 .. i*12+12, first byte in the MSBs.
    function automatic logic [95:0] make_word(input int i);
        logic [95:0] w;
        w = '0;
        for (int j = 0; j < 12; j++) w[95-8*j -: 8] = 8'(i*12 + j + 1);
        return w;
    endfunction

    // Expected {B,G,R} of pixel k of word i.
    function automatic logic [23:0] px(input int i, input int k);
        return {8'(i*12 + 3*k + 1), 8'(i*12 + 3*k + 2), 8'(i*12 + 3*k + 3)};
    endfunction

    task automatic fifo_refresh();
        word_empty  = (fifo_q.size() == 0);
        word_data   = word_empty ? '0 : make_word(fifo_q[0]);
        word_data6  = make_word(idx6);
        word_empty6 = 1'b0;
    endtask

    task automatic push_word(input int i);
        fifo_q.push_back(i);
        for (int k = 0; k < 4; k++) exp_q.push_back(px(i, k));
        fifo_refresh();
    endtask

    task automatic push_black(input int npix);
        for (int k = 0; k < npix; k++) exp_q.push_back(24'h0);
    endtask

    task automatic clear_stats();
        n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_rden = 0; first_de = -1; last_de = -1;
        n_hs6 = 0; n_vs6 = 0; n_de6 = 0; n_fs6 = 0; n_rden6 = 0;
    endtask

    // One clock: FIFO pop on sampled word_rden, stats, pixel scoreboards.
    task automatic step();
        logic        rs, rs6;
        logic [23:0] e;
        int          tmp;
        @(negedge clk);
        rs  = word_rden;
        rs6 = word_rden6;
        vectors++;
        if (word_rden === 1'b1 && word_empty === 1'b1) begin
            miscompares++;
            $display("FAIL rden_while_empty: word_rden=%b word_empty=%b", word_rden, word_empty);
        end
        if (rs === 1'b1) n_rden++;
        if (rs6 === 1'b1) n_rden6++;
        @(posedge clk);
        #1;
        if (rs === 1'b1 && fifo_q.size() > 0) tmp = fifo_q.pop_front();
        if (rs6 === 1'b1) idx6++;
        fifo_refresh();
        #1;
        sidx++;
        if (lcd_hsync === 1'b0) n_hs++;
        if (lcd_vsync === 1'b0) n_vs++;
        if (frame_start === 1'b1) n_fs++;
        if (lcd_hsync6 === 1'b0) n_hs6++;
        if (lcd_vsync6 === 1'b0) n_vs6++;
        if (frame_start6 === 1'b1) n_fs6++;
        vectors++;
        if (lcd_de === 1'b1) begin
            n_de++;
            if (first_de < 0) first_de = sidx;
            last_de = sidx;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL pixel: got %h with DE, expected no DE (scoreboard empty)", {lcd_b, lcd_g, lcd_r});
            end else begin
                e = exp_q.pop_front();
                if ({lcd_b, lcd_g, lcd_r} !== e) begin
                    miscompares++;
                    $display("FAIL pixel: got BGR %h, expected %h at step %0d", {lcd_b, lcd_g, lcd_r}, e, sidx);
                end
            end
        end else if ({lcd_b, lcd_g, lcd_r} !== 24'h0) begin
            miscompares++;
            $display("FAIL rgb_outside_de: got %h, expected 000000", {lcd_b, lcd_g, lcd_r});
        end
        vectors++;
        if (lcd_de6 === 1'b1) begin
            n_de6++;
            if (exp6_q.size() == 0) begin
                miscompares++;
                $display("FAIL pixel6: got %h with DE, expected no DE", {lcd_b6, lcd_g6, lcd_r6});
            end else begin
                e = exp6_q.pop_front();
                if ({lcd_b6, lcd_g6, lcd_r6} !== e) begin
                    miscompares++;
                    $display("FAIL pixel6: got BGR %h, expected %h", {lcd_b6, lcd_g6, lcd_r6}, e);
                end
            end
        end else if ({lcd_b6, lcd_g6, lcd_r6} !== 24'h0) begin
            miscompares++;
            $display("FAIL rgb6_outside_de: got %h, expected 000000", {lcd_b6, lcd_g6, lcd_r6});
        end
    endtask

    task automatic run_to(input int s);
        while (sidx < s) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; enable = 1'b0; enable6 = 1'b0; clr = 1'b0; idx6 = 0;
        fifo_q.delete(); exp_q.delete(); exp6_q.delete();
        fifo_refresh();
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; enable6 = 1'b0; clr = 1'b0;
        fifo_refresh();
        step(); step();
        vectors++;
        if ({lcd_hsync, lcd_vsync, lcd_de, frame_start, underflow, word_rden} !== 6'b110000) begin
            miscompares++;
            $display("FAIL reset_ctrl: got hs/vs/de/fs/uf/rden=%b, expected 110000",
                     {lcd_hsync, lcd_vsync, lcd_de, frame_start, underflow, word_rden});
        end
        vectors++;
        if ({lcd_r, lcd_g, lcd_b} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_rgb: got %h, expected 000000", {lcd_r, lcd_g, lcd_b});
        end
        vectors++;
        if (lcd_dclk !== clk || lcd_dclk6 !== clk) begin
            miscompares++;
            $display("FAIL dclk: got %b/%b, expected %b", lcd_dclk, lcd_dclk6, clk);
        end
        rst_n = 1'b1;
        step(); step();
        vectors++;
        if ({lcd_hsync, lcd_vsync, lcd_de, frame_start} !== 4'b1100) begin
            miscompares++;
            $display("FAIL idle_after_reset: got hs/vs/de/fs=%b, expected 1100",
                     {lcd_hsync, lcd_vsync, lcd_de, frame_start});
        end
    endtask

    task automatic test_timing();
        do_reset();
        for (int i = 0; i < 6; i++) push_word(i);
        enable = 1'b1; sidx = 0; clear_stats();
        step();
        vectors++;
        if (frame_start !== 1'b0) begin
            miscompares++;
            $display("FAIL fs_early: got %b at first cycle, expected 0", frame_start);
        end
        step();
        vectors++;
        if ({frame_start, lcd_hsync, lcd_vsync} !== 3'b100) begin
            miscompares++;
            $display("FAIL fs_second_cycle: got fs/hs/vs=%b, expected 100", {frame_start, lcd_hsync, lcd_vsync});
        end
        run_to(85);
        vectors++;
        if (n_hs !== 12 || n_vs !== 14 || n_de !== 24 || n_fs !== 1) begin
            miscompares++;
            $display("FAIL frame_counts: got hs=%0d vs=%0d de=%0d fs=%0d, expected 12 14 24 1", n_hs, n_vs, n_de, n_fs);
        end
        vectors++;
        if (first_de !== 34 || last_de !== 69) begin
            miscompares++;
            $display("FAIL de_window: got first=%0d last=%0d, expected 34 69", first_de, last_de);
        end
        vectors++;
        if (n_rden !== 6 || exp_q.size() !== 0 || underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_words: got rden=%0d left=%0d uf=%b, expected 6 0 0", n_rden, exp_q.size(), underflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        push_word(0);
        push_black(4);
        enable = 1'b1; sidx = 0; clear_stats();
        run_to(37);
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_early: got %b, expected 0", underflow);
        end
        run_to(42);
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uf_set: got %b, expected 1", underflow);
        end
        for (int i = 1; i < 5; i++) push_word(i);
        run_to(85);
        vectors++;
        if (n_de !== 24 || n_rden !== 5 || exp_q.size() !== 0 || underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uf_frame: got de=%0d rden=%0d left=%0d uf=%b, expected 24 5 0 1",
                     n_de, n_rden, exp_q.size(), underflow);
        end
        push_black(24);
        clr = 1'b1;
        step();
        clr = 1'b0;
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_clear: got %b, expected 0", underflow);
        end
        run_to(117);
        vectors++;
        if (underflow !== 1'b0) begin
            miscompares++;
            $display("FAIL uf_stay_clear: got %b, expected 0", underflow);
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uf_set_priority: got %b, expected 1", underflow);
        end
    endtask

    task automatic test_stop();
        do_reset();
        for (int i = 0; i < 6; i++) push_word(i);
        enable = 1'b1; sidx = 0; clear_stats();
        run_to(47);
        enable = 1'b0;
        run_to(85);
        vectors++;
        if (n_de !== 24 || n_fs !== 1 || n_rden !== 6 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL stop_frame: got de=%0d fs=%0d rden=%0d left=%0d, expected 24 1 6 0",
                     n_de, n_fs, n_rden, exp_q.size());
        end
        clear_stats();
        run_to(95);
        vectors++;
        if (n_de !== 0 || n_fs !== 0 || n_hs !== 0 || n_vs !== 0 || n_rden !== 0) begin
            miscompares++;
            $display("FAIL stop_idle: got de=%0d fs=%0d hs=%0d vs=%0d rden=%0d, expected all 0",
                     n_de, n_fs, n_hs, n_vs, n_rden);
        end
        for (int i = 6; i < 18; i++) push_word(i);
        enable = 1'b1; sidx = 0; clear_stats();
        run_to(20);
        enable = 1'b0;
        run_to(50);
        enable = 1'b1;
        run_to(86);
        vectors++;
        if (frame_start !== 1'b1) begin
            miscompares++;
            $display("FAIL restart_no_gap: got fs=%b at step 86, expected 1", frame_start);
        end
        run_to(169);
        vectors++;
        if (n_fs !== 2 || n_de !== 48 || n_rden !== 12 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL restart_frames: got fs=%0d de=%0d rden=%0d left=%0d, expected 2 48 12 0",
                     n_fs, n_de, n_rden, exp_q.size());
        end
        enable = 1'b0;
    endtask

    task automatic test_h_active6();
        do_reset();
        for (int l = 0; l < 3; l++) begin
            for (int k = 0; k < 4; k++) exp6_q.push_back(px(2*l, k));
            for (int k = 0; k < 2; k++) exp6_q.push_back(px(2*l + 1, k));
        end
        enable6 = 1'b1; sidx = 0; clear_stats();
        run_to(73);
        vectors++;
        if (n_rden6 !== 6 || n_de6 !== 18 || exp6_q.size() !== 0) begin
            miscompares++;
            $display("FAIL ha6_words: got rden=%0d de=%0d left=%0d, expected 6 18 0",
                     n_rden6, n_de6, exp6_q.size());
        end
        vectors++;
        if (n_fs6 !== 1 || n_hs6 !== 12 || n_vs6 !== 12 || underflow6 !== 1'b0) begin
            miscompares++;
            $display("FAIL ha6_timing: got fs=%0d hs=%0d vs=%0d uf=%b, expected 1 12 12 0",
                     n_fs6, n_hs6, n_vs6, underflow6);
        end
        enable6 = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) push_word(i);
        enable = 1'b1; sidx = 0; clear_stats();
        run_to(36);
        vectors++;
        if (lcd_de !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_de: got %b, expected 1", lcd_de);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({lcd_hsync, lcd_vsync, lcd_de, frame_start, word_rden} !== 5'b11000
            || {lcd_r, lcd_g, lcd_b} !== 24'h0) begin
            miscompares++;
            $display("FAIL async_reset: got hs/vs/de/fs/rden=%b rgb=%h, expected 11000 000000",
                     {lcd_hsync, lcd_vsync, lcd_de, frame_start, word_rden}, {lcd_r, lcd_g, lcd_b});
        end
        fifo_q.delete(); exp_q.delete();
        fifo_refresh();
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) push_word(i);
        sidx = 0; clear_stats();
        run_to(85);
        vectors++;
        if (n_fs !== 1 || first_de !== 34 || n_de !== 24 || n_rden !== 6 || exp_q.size() !== 0) begin
            miscompares++;
            $display("FAIL post_reset_frame: got fs=%0d first_de=%0d de=%0d rden=%0d left=%0d, expected 1 34 24 6 0",
                     n_fs, first_de, n_de, n_rden, exp_q.size());
        end
        enable = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0; sidx = 0; idx6 = 0;
        rst_n = 1'b0; enable = 1'b0; enable6 = 1'b0; clr = 1'b0;
        clear_stats();
        fifo_refresh();
        test_reset();
        test_timing();
        test_underflow();
        test_stop();
        test_h_active6();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
